// File: rtl/multicycle_control.sv
// multicycle_control: five-state IF/ID/EX/MEM/WB sequencer for the multi-cycle core
//   in : clk, rst (async, active-low), op_class[2:0], dec_aluop[3:0], alu_zero, mem_ready
//   out: mem_req, mem_we, ir_write, pc_write, pc_src[1:0], alu_src_a, alu_src_b[1:0],
//        AluOp1[3:0], target_write, reg_write, mem_to_reg, illegal, bus_err, instret[31:0]
module multicycle_control #(
    parameter logic [3:0] ALUOP_ADD   = 4'd1,
    parameter logic [3:0] ALUOP_SUB   = 4'd2,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op_class,
    input  logic [3:0]  dec_aluop,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  AluOp1,
    output logic        target_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
    localparam logic [2:0] C_RALU = 3'd0, C_IALU = 3'd1, C_LOAD = 3'd2, C_STORE = 3'd3,
                           C_BRANCH = 3'd4, C_JUMP = 3'd5, C_NOP = 3'd6, C_ILLEGAL = 3'd7;
    state_t     state;
    logic [2:0] op_q;
    logic [7:0] wd_cnt;
    logic       run;
    logic       req;
    logic       timeout;
    logic       retire;
    // run holds every output low for the first cycle after reset release,
    // so the first fetch is issued one cycle after rst deasserts
    assign req     = run && (state == S_IF || state == S_MEM);
    // mem_ready in the final wait cycle beats the timeout
    assign timeout = req && !mem_ready && (wd_cnt == 8'(MEM_TIMEOUT - 1));
    assign retire  = run && ((state == S_ID && op_class == C_NOP) ||
                             (state == S_EX && (op_q == C_BRANCH || op_q == C_JUMP)) ||
                             (state == S_MEM && mem_ready) ||
                             state == S_WB);
    always_comb begin
        mem_req      = req;
        mem_we       = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        AluOp1       = 4'd0;
        target_write = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        illegal      = 1'b0;
        bus_err      = timeout;
        if (run) begin
            case (state)
                S_IF: begin
                    alu_src_b = 2'd1;
                    AluOp1    = ALUOP_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_ID: begin
                    alu_src_b    = 2'd3;
                    AluOp1       = ALUOP_ADD;
                    target_write = 1'b1;
                    illegal      = op_class == C_ILLEGAL;
                end
                S_EX: begin
                    case (op_q)
                        C_RALU: begin
                            alu_src_a = 1'b1;
                            AluOp1    = dec_aluop;
                        end
                        C_IALU: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'd2;
                            AluOp1    = dec_aluop;
                        end
                        C_LOAD, C_STORE: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'd2;
                            AluOp1    = ALUOP_ADD;
                        end
                        C_BRANCH: begin
                            alu_src_a = 1'b1;
                            AluOp1    = ALUOP_SUB;
                            pc_src    = 2'd1;
                            pc_write  = alu_zero;
                        end
                        C_JUMP: begin
                            pc_src   = 2'd2;
                            pc_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_we     = op_q == C_STORE;
                    reg_write  = mem_ready && op_q == C_LOAD;
                    mem_to_reg = mem_ready && op_q == C_LOAD;
                end
                S_WB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IF;
            op_q    <= C_NOP;
            wd_cnt  <= 8'd0;
            run     <= 1'b0;
            instret <= 32'd0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            instret <= instret + {31'd0, retire};
            wd_cnt  <= (req && !mem_ready && !timeout) ? wd_cnt + 8'd1 : 8'd0;
            case (state)
                S_IF:  state <= mem_ready ? S_ID : S_IF;
                S_ID: begin
                    op_q  <= op_class;
                    state <= (op_class == C_NOP || op_class == C_ILLEGAL) ? S_IF : S_EX;
                end
                S_EX:  state <= (op_q == C_LOAD || op_q == C_STORE) ? S_MEM :
                                (op_q == C_RALU || op_q == C_IALU) ? S_WB : S_IF;
                S_MEM: state <= (mem_ready || timeout) ? S_IF : S_MEM;
                default: state <= S_IF;
            endcase
        end
    end
endmodule
